operand_stage: RTL and testbench

- Operand-fetch pipeline stage directly upstream of the 16-bit ALU.
- Accepts decoded instruction fields and reads two operands from an embedded 16x16 register file, with write-back bypass.
- Holds a, b and op_alu in a valid/ready pipeline register that drives the ALU inputs.
- Also owns the architectural zero/carry flag register, loaded from the ALU flag outputs.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/operand_stage_regfile.sv | 55 +++++
 rtl/operand_stage.sv | 126 ++++++++++++
 tb/tb_operand_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and ALU operation encodings.
// Imported by the operand stage and its register file.
// No logic lives here.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int NUM_REGS = 1 << REG_AW;

    // ALU operation codes carried through the operand stage untouched
    typedef enum logic [2:0] {
        OP_MOVA = 3'b000,
        OP_NOTA = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_NEGA = 3'b110,
        OP_NEGB = 3'b111
    } op_alu_e;

    typedef logic [2:0] op_alu_t;

endpackage

// File: rtl/operand_stage_regfile.sv
// 2R/1W register file with write-back bypass; R0 reads as zero and ignores writes.
// Latency: reads are combinational, writes land on the rising edge.
// Backpressure: none, both ports are always available.
module regfile #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    import cpu_pkg::*;

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] mem [NREG];
    logic              wr_live;

    // A write to R0 is architecturally a no-op, so it never counts as live
    assign wr_live = we && (wa != '0);

    // Storage: cleared on reset, one write per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    // Read ports: R0 forced to zero, same-cycle write forwarded to the reader
    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_live && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_live && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch ahead of the ALU: reads a/b (bypassed), holds them with op in a pipeline register; owns Z/C flags.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, single entry, no skid; held operands refreshed by write-back while stalled.
module operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_ra1,
    input  logic [REG_AW-1:0] in_ra2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [2:0]        in_op_alu,
    input  logic [REG_AW-1:0] in_wa,
    input  logic              in_we,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_op_alu,
    output logic [REG_AW-1:0] out_wa,
    output logic              out_we,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              zero_flag,
    output logic              carry_flag
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] b_sel;
    logic              accept;
    logic              stalled;
    logic              wb_live;
    logic              hit_a;
    logic              hit_b;

    // Source info of the held instruction, needed to refresh it during a stall
    logic [REG_AW-1:0] held_ra1;
    logic [REG_AW-1:0] held_ra2;
    logic              held_use_imm;
    op_alu_t           op_next;

    regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (in_ra1),
        .ra2   (in_ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (wb_we),
        .wa    (wb_wa),
        .wd    (wb_wd)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign stalled  = out_valid && !out_ready;
    assign b_sel    = in_use_imm ? in_imm : rd2;
    assign op_next  = in_op_alu;

    // An older instruction retiring while we stall may target our sources
    assign wb_live = wb_we && (wb_wa != '0);
    assign hit_a   = wb_live && (wb_wa == held_ra1);
    assign hit_b   = wb_live && !held_use_imm && (wb_wa == held_ra2);

    // Pipeline register: flush beats accept; consume+accept swaps with no bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_a        <= '0;
            out_b        <= '0;
            out_op_alu   <= '0;
            out_wa       <= '0;
            out_we       <= 1'b0;
            held_ra1     <= '0;
            held_ra2     <= '0;
            held_use_imm <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_a        <= rd1;
            out_b        <= b_sel;
            out_op_alu   <= op_next;
            out_wa       <= in_wa;
            out_we       <= in_we;
            held_ra1     <= in_ra1;
            held_ra2     <= in_ra2;
            held_use_imm <= in_use_imm;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (stalled) begin
            if (hit_a) begin
                out_a <= wb_wd;
            end
            if (hit_b) begin
                out_b <= wb_wd;
            end
        end
    end

    // Architectural flags, loaded from the ALU outputs on request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (flag_we) begin
            zero_flag  <= alu_zero;
            carry_flag <= alu_carry;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ra1;
    logic [3:0]  in_ra2;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic [2:0]  in_op_alu;
    logic [3:0]  in_wa;
    logic        in_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [2:0]  out_op_alu;
    logic [3:0]  out_wa;
    logic        out_we;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [15:0] wb_wd;
    logic        flag_we;
    logic        alu_zero;
    logic        alu_carry;
    logic        zero_flag;
    logic        carry_flag;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural registers plus the one instruction in the stage
    logic [15:0] m_reg [16];
    logic        m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [2:0]  m_op;
    logic [3:0]  m_wa;
    logic        m_we;
    logic [3:0]  m_ra1;
    logic [3:0]  m_ra2;
    logic        m_imm;
    logic        m_z;
    logic        m_c;

    operand_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ra1     (in_ra1),
        .in_ra2     (in_ra2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_op_alu  (in_op_alu),
        .in_wa      (in_wa),
        .in_we      (in_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_op_alu (out_op_alu),
        .out_wa     (out_wa),
        .out_we     (out_we),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .flag_we    (flag_we),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    // Value an instruction sees for register r this cycle (R0 is zero, write-back forwarded)
    function automatic logic [15:0] mread(input logic [3:0] r);
        if (r == 4'd0) return 16'h0000;
        if (wb_we && wb_wa == r) return wb_wd;
        return m_reg[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_wa = '0; m_we = 1'b0;
        m_ra1 = '0; m_ra2 = '0; m_imm = 1'b0; m_z = 1'b0; m_c = 1'b0;
    endtask

    task automatic idle();
        in_valid = 0; in_ra1 = 0; in_ra2 = 0; in_use_imm = 0; in_imm = 0;
        in_op_alu = 0; in_wa = 0; in_we = 0; flush = 0; out_ready = 1;
        wb_we = 0; wb_wa = 0; wb_wd = 0; flag_we = 0; alu_zero = 0; alu_carry = 0;
    endtask

    // Advance one clock: work out what the stage should hold next, then take the edge
    task automatic cycle();
        logic        nv, nimm, nwe, nz, nc, take;
        logic [15:0] na, nb;
        logic [2:0]  nop;
        logic [3:0]  nwa, nr1, nr2;
        nv = m_valid; na = m_a; nb = m_b; nop = m_op; nwa = m_wa; nwe = m_we;
        nr1 = m_ra1; nr2 = m_ra2; nimm = m_imm; nz = m_z; nc = m_c;
        take = in_valid && (!m_valid || out_ready);
        if (flush) begin
            nv = 1'b0;
        end else if (take) begin
            nv = 1'b1;
            na = mread(in_ra1);
            nb = in_use_imm ? in_imm : mread(in_ra2);
            nop = in_op_alu; nwa = in_wa; nwe = in_we;
            nr1 = in_ra1; nr2 = in_ra2; nimm = in_use_imm;
        end else if (m_valid && out_ready) begin
            nv = 1'b0;
        end else if (m_valid) begin
            if (m_ra1 != 0) na = mread(m_ra1);
            if (!m_imm && m_ra2 != 0) nb = mread(m_ra2);
        end
        if (flag_we) begin
            nz = alu_zero; nc = alu_carry;
        end
        @(posedge clk);
        #1;
        if (wb_we && wb_wa != 0) m_reg[wb_wa] = wb_wd;
        m_valid = nv; m_a = na; m_b = nb; m_op = nop; m_wa = nwa; m_we = nwe;
        m_ra1 = nr1; m_ra2 = nr2; m_imm = nimm; m_z = nz; m_c = nc;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        checks++;
        if (out_a !== 16'h0 || out_b !== 16'h0 || out_op_alu !== 3'b0 || out_wa !== 4'h0 || out_we !== 1'b0) begin
            errors++; $display("FAIL reset_payload got a=%h b=%h op=%0d wa=%0d we=%0b want all zero", out_a, out_b, out_op_alu, out_wa, out_we);
        end
        checks++;
        if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b want=00", zero_flag, carry_flag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_read();
        idle();
        wb_we = 1; wb_wa = 3; wb_wd = 16'h1234; cycle();
        wb_wa = 5; wb_wd = 16'h0F0F; cycle();
        wb_we = 0;
        in_valid = 1; in_ra1 = 3; in_ra2 = 5; in_op_alu = 3'b010; in_wa = 7; in_we = 1;
        cycle();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL read_valid got=%0b want=1", out_valid); end
        checks++;
        if (out_a !== 16'h1234 || out_b !== 16'h0F0F) begin errors++; $display("FAIL read_operands got a=%h b=%h want a=1234 b=0f0f", out_a, out_b); end
        checks++;
        if (out_op_alu !== 3'b010 || out_wa !== 4'd7 || out_we !== 1'b1) begin
            errors++; $display("FAIL read_fields got op=%0d wa=%0d we=%0b want op=2 wa=7 we=1", out_op_alu, out_wa, out_we);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL read_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_bypass();
        idle();
        in_valid = 1; in_ra1 = 3; in_ra2 = 0; in_op_alu = 3'b000;
        wb_we = 1; wb_wa = 3; wb_wd = 16'hBEEF;
        cycle();
        checks++;
        if (out_a !== 16'hBEEF || out_b !== 16'h0000) begin errors++; $display("FAIL bypass_a got a=%h b=%h want a=beef b=0000", out_a, out_b); end
        in_ra1 = 0; in_ra2 = 0; wb_wa = 0; wb_wd = 16'hFFFF;
        cycle();
        checks++;
        if (out_a !== 16'h0000) begin errors++; $display("FAIL r0_bypass got=%h want=0000", out_a); end
        wb_we = 0;
        cycle();
        checks++;
        if (out_a !== 16'h0000 || out_b !== 16'h0000) begin errors++; $display("FAIL r0_read got a=%h b=%h want 0000", out_a, out_b); end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_stall_refresh();
        idle();
        out_ready = 0;
        in_valid = 1; in_ra1 = 3; in_ra2 = 5; in_op_alu = 3'b011;
        cycle();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'hBEEF || out_b !== 16'h0F0F) begin
            errors++; $display("FAIL stall_load got v=%0b a=%h b=%h want v=1 a=beef b=0f0f", out_valid, out_a, out_b);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
        wb_we = 1; wb_wa = 5; wb_wd = 16'hAAAA;
        cycle();
        checks++;
        if (out_b !== 16'hAAAA || out_a !== 16'hBEEF) begin errors++; $display("FAIL stall_refresh_b got a=%h b=%h want a=beef b=aaaa", out_a, out_b); end
        wb_wa = 3; wb_wd = 16'h5555;
        cycle();
        wb_we = 0;
        checks++;
        if (out_a !== 16'h5555 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_refresh_a got a=%h v=%0b want a=5555 v=1", out_a, out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_ready got=%0b want=0", in_ready); end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b want=1", in_ready); end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_imm();
        idle();
        out_ready = 0;
        in_valid = 1; in_use_imm = 1; in_imm = 16'h8000; in_ra1 = 0; in_ra2 = 5;
        cycle();
        in_valid = 0; in_use_imm = 0;
        checks++;
        if (out_b !== 16'h8000) begin errors++; $display("FAIL imm_select got=%h want=8000", out_b); end
        wb_we = 1; wb_wa = 5; wb_wd = 16'h1111;
        cycle();
        wb_we = 0;
        checks++;
        if (out_b !== 16'h8000) begin errors++; $display("FAIL imm_no_refresh got=%h want=8000", out_b); end
        out_ready = 1;
        cycle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_use_imm = 1; in_imm = 16'h0100 + 16'(i); in_op_alu = 3'(i + 1);
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_op_alu !== 3'(i + 1) || out_b !== 16'h0100 + 16'(i)) begin
                errors++; $display("FAIL b2b_beat%0d got v=%0b op=%0d b=%h want v=1 op=%0d b=%h", i, out_valid, out_op_alu, out_b, i + 1, 16'h0100 + 16'(i));
            end
        end
        flush = 1; in_op_alu = 3'b111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
        cycle();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%0b want=0", out_valid); end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_dropped got=%0b want=0", out_valid); end
    endtask

    task automatic test_flags();
        idle();
        flag_we = 1; alu_zero = 1; alu_carry = 1;
        cycle();
        checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b1) begin errors++; $display("FAIL flags_load got=%0b%0b want=11", zero_flag, carry_flag); end
        flag_we = 0; alu_zero = 0; alu_carry = 0;
        cycle();
        checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b1) begin errors++; $display("FAIL flags_hold got=%0b%0b want=11", zero_flag, carry_flag); end
        flag_we = 1; alu_zero = 0; alu_carry = 1;
        cycle();
        flag_we = 0;
        checks++;
        if (zero_flag !== 1'b0 || carry_flag !== 1'b1) begin errors++; $display("FAIL flags_mixed got=%0b%0b want=01", zero_flag, carry_flag); end
    endtask

    task automatic test_random();
        int bad = 0;
        idle();
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_ra1     = 4'($urandom);
            in_ra2     = 4'($urandom);
            in_use_imm = ($urandom_range(0, 3) == 0);
            in_imm     = 16'($urandom);
            in_op_alu  = 3'($urandom);
            in_wa      = 4'($urandom);
            in_we      = 1'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            wb_we      = 1'($urandom);
            wb_wa      = ($urandom_range(0, 2) == 0) ? m_ra1 : (($urandom_range(0, 1) == 0) ? m_ra2 : 4'($urandom));
            wb_wd      = 16'($urandom);
            flag_we    = 1'($urandom);
            alu_zero   = 1'($urandom);
            alu_carry  = 1'($urandom);
            #1;
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rnd_in_ready n=%0d got=%0b want=%0b", n, in_ready, !m_valid || out_ready);
            end
            cycle();
            checks++;
            if (out_valid !== m_valid || zero_flag !== m_z || carry_flag !== m_c ||
                (m_valid && (out_a !== m_a || out_b !== m_b || out_op_alu !== m_op || out_wa !== m_wa || out_we !== m_we))) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rnd_state n=%0d got v=%0b a=%h b=%h op=%0d wa=%0d we=%0b z=%0b c=%0b want v=%0b a=%h b=%h op=%0d wa=%0d we=%0b z=%0b c=%0b",
                    n, out_valid, out_a, out_b, out_op_alu, out_wa, out_we, zero_flag, carry_flag,
                    m_valid, m_a, m_b, m_op, m_wa, m_we, m_z, m_c);
            end
        end
    endtask

    task automatic test_async_reset();
        idle();
        wb_we = 1; wb_wa = 3; wb_wd = 16'h7777;
        flag_we = 1; alu_zero = 1; alu_carry = 1;
        out_ready = 0; in_valid = 1; in_ra1 = 4; in_ra2 = 6; in_use_imm = 0;
        cycle();
        idle();
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b1 || zero_flag !== 1'b1) begin errors++; $display("FAIL areset_setup got v=%0b z=%0b want v=1 z=1", out_valid, zero_flag); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0 || out_a !== 16'h0) begin
            errors++; $display("FAIL areset_immediate got v=%0b z=%0b c=%0b a=%h want all zero", out_valid, zero_flag, carry_flag, out_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        out_ready = 1;
        in_valid = 1; in_ra1 = 3; in_ra2 = 3;
        cycle();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== 16'h0000 || out_b !== 16'h0000) begin
            errors++; $display("FAIL areset_regs_cleared got v=%0b a=%h b=%h want v=1 a=0000 b=0000", out_valid, out_a, out_b);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_read();
        test_bypass();
        test_stall_refresh();
        test_imm();
        test_back_to_back();
        test_flags();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
